// File: rtl/fp_div_pkg.sv
// Shared FP32 field positions, limits and controller state type for the sequential divider.
package fp_div_pkg;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {IDLE, SETUP, ITER, NORM, DONE} state_e;
endpackage

// File: rtl/fp_div_seq_step.sv
// One restoring-division step: conditional subtract, quotient bit, shift left.
module mantissa_div_step #(
  parameter int W = 25
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] m,
  output logic [W-1:0] r_nxt,
  output logic         q
);
  logic [W-1:0] diff;

  always_comb begin
    q     = (r >= m);
    diff  = q ? (r - m) : r;
    r_nxt = diff << 1;
  end
endmodule

// File: rtl/fp_div_seq.sv
// Sequential FP32 divider: handshaked operands, one quotient bit per clock, flush-to-zero.
// Define FP_DIV_ROUND_EN for round-to-nearest-even; default build truncates.
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int BIT_WIDTH = 23,
  parameter int EXP_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        div_by_zero,
  output logic        busy
);
  localparam int MW    = BIT_WIDTH + 2;
  localparam int QW    = BIT_WIDTH + 3;
  localparam int EW    = EXP_WIDTH + 2;
  localparam int CNT_W = $clog2(BIT_WIDTH + 4);
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(BIT_WIDTH + 2);
  localparam logic signed [EW-1:0] BIAS_S   = EW'(EXP_BIAS);
  localparam logic signed [EW-1:0] EMAX_S   = EW'(EXP_MAX);
  localparam logic signed [EW-1:0] ONE_S    = EW'(1);
  localparam logic signed [EW-1:0] ZERO_S   = '0;

  state_e state_q, state_d;
  logic [31:0]          a_q, b_q, out_q;
  logic [MW-1:0]        r_q, m_q, r_nxt;
  logic [QW-1:0]        q_q;
  logic signed [EW-1:0] exp_q;
  logic                 sign_q, dbz_q, q_bit;
  logic [CNT_W-1:0]     cnt_q;

  // operand classification; a_q/b_q stay put until the next accept
  logic [EXP_WIDTH-1:0] a_e, b_e;
  logic [BIT_WIDTH-1:0] a_f, b_f;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s;
  logic special, spec_dbz;
  logic [31:0] spec_res;

  always_comb begin
    a_e = a_q[EXP_MSB:EXP_LSB];
    b_e = b_q[EXP_MSB:EXP_LSB];
    a_f = a_q[FRAC_MSB:0];
    b_f = b_q[FRAC_MSB:0];
    s   = a_q[SIGN_BIT] ^ b_q[SIGN_BIT];
    a_zero = (a_e == '0);
    b_zero = (b_e == '0);
    a_inf  = (a_e == '1) && (a_f == '0);
    b_inf  = (b_e == '1) && (b_f == '0);
    a_nan  = (a_e == '1) && (a_f != '0);
    b_nan  = (b_e == '1) && (b_f != '0);
    special  = 1'b1;
    spec_dbz = 1'b0;
    spec_res = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) spec_res = QNAN;
    else if (a_inf)  spec_res = {s, POS_INF[30:0]};
    else if (b_inf)  spec_res = {s, 31'b0};
    else if (b_zero) begin spec_res = {s, POS_INF[30:0]}; spec_dbz = 1'b1; end
    else if (a_zero) spec_res = {s, 31'b0};
    else             special = 1'b0;
  end

  // normalize / round / range-check the finished quotient
  logic                 hi, guard;
  logic [BIT_WIDTH-1:0] frac, frac_r;
  logic signed [EW-1:0] e_r;
  logic [31:0]          norm_res;
`ifdef FP_DIV_ROUND_EN
  logic sticky, inc, carry;
`else
  logic unused_guard;
`endif

  always_comb begin
    hi    = q_q[QW-1];
    frac  = hi ? q_q[QW-2:2] : q_q[QW-3:1];
    guard = hi ? q_q[1] : q_q[0];
    e_r   = hi ? exp_q : exp_q - ONE_S;
`ifdef FP_DIV_ROUND_EN
    sticky = (r_q != '0) | (hi & q_q[0]);
    inc    = guard & (sticky | frac[0]);
    {carry, frac_r} = {1'b0, frac} + {{BIT_WIDTH{1'b0}}, inc};
    if (carry) e_r = e_r + ONE_S;
`else
    frac_r       = frac;
    unused_guard = guard;
`endif
    if (e_r >= EMAX_S)      norm_res = {sign_q, POS_INF[30:0]};
    else if (e_r <= ZERO_S) norm_res = {sign_q, 31'b0};
    else                    norm_res = {sign_q, e_r[EXP_WIDTH-1:0], frac_r};
  end

  mantissa_div_step #(.W(MW)) u_step (
    .r     (r_q),
    .m     (m_q),
    .r_nxt (r_nxt),
    .q     (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // specials detour through NORM so their result lands two edges after accept
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = SETUP;
      end
      SETUP: state_d = special ? NORM : ITER;
      ITER:  if (cnt_q == '0) state_d = NORM;
      NORM:  state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0; b_q <= '0; out_q <= '0;
      r_q <= '0; m_q <= '0; q_q <= '0;
      exp_q <= '0; sign_q <= 1'b0; dbz_q <= 1'b0; cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q <= in0;
          b_q <= in1;
        end
        SETUP: begin
          sign_q <= s;
          exp_q  <= $signed({2'b00, a_e}) - $signed({2'b00, b_e}) + BIAS_S;
          r_q    <= {1'b0, 1'b1, a_f};
          m_q    <= {1'b0, 1'b1, b_f};
          q_q    <= '0;
          cnt_q  <= CNT_LOAD;
        end
        ITER: begin
          r_q <= r_nxt;
          q_q <= {q_q[QW-2:0], q_bit};
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        NORM: begin
          out_q <= special ? spec_res : norm_res;
          dbz_q <= spec_dbz;
        end
        default: ;
      endcase
    end
  end

  assign out         = out_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_fp_div_seq.sv
// Randomized and directed bench for fp_div_seq against an integer-division reference model.
module tb_fp_div_seq;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in0 = '0, in1 = '0;
  logic        in_ready, out_valid, div_by_zero, busy;
  logic [31:0] out;
  int total = 0, bad = 0;

  fp_div_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // quotient = floor(ma*2^25/mb), then normalize/round from the field rules
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic dz, output logic sp);
    logic s, az, bz, ai, bi, an, bn, hi;
    int ea, eb, e;
    logic [63:0] num, mb, qq, rem, fr;
`ifdef FP_DIV_ROUND_EN
    logic g, st;
`endif
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    az = (ea == 0);  bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 0);  bi = (eb == 255) && (b[22:0] == 0);
    an = (ea == 255) && (a[22:0] != 0);  bn = (eb == 255) && (b[22:0] != 0);
    dz = 1'b0;
    sp = 1'b1;
    r  = '0;
    if (an || bn || (az && bz) || (ai && bi)) r = 32'h7FC00000;
    else if (ai) r = {s, 8'hFF, 23'h0};
    else if (bi) r = {s, 31'h0};
    else if (bz) begin r = {s, 8'hFF, 23'h0}; dz = 1'b1; end
    else if (az) r = {s, 31'h0};
    else begin
      sp  = 1'b0;
      num = (64'h800000 + {41'b0, a[22:0]}) << 25;
      mb  = 64'h800000 + {41'b0, b[22:0]};
      qq  = num / mb;
      rem = num % mb;
      e   = ea - eb + 127;
      hi  = (qq >= 64'h2000000);
      if (hi) fr = (qq >> 2) & 64'h7FFFFF;
      else begin fr = (qq >> 1) & 64'h7FFFFF; e = e - 1; end
`ifdef FP_DIV_ROUND_EN
      g  = hi ? qq[1] : qq[0];
      st = (rem != 0) || (hi && qq[0]);
      if (g && (st || fr[0])) fr = fr + 1;
      if (fr == 64'h800000) begin fr = 0; e = e + 1; end
`endif
      if (e >= 255)    r = {s, 8'hFF, 23'h0};
      else if (e <= 0) r = {s, 31'h0};
      else             r = {s, 8'(e), fr[22:0]};
    end
  endfunction

  function automatic logic [31:0] rnd_fp();
    int k = $urandom_range(0, 15);
    logic [7:0]  e;
    logic [22:0] f = 23'($urandom);
    if (k == 0)      e = 8'h00;
    else if (k == 1) e = 8'hFF;
    else if (k < 9)  e = 8'($urandom_range(97, 157));
    else             e = 8'($urandom_range(1, 254));
    if ((k == 1 || k == 2) && ($urandom_range(0, 1) == 0)) f = '0;
    return {1'($urandom), e, f};
  endfunction

  // called #1 after a posedge with the DUT idle and out_ready high
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic dz, output int lat);
    in0 = a; in1 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r  = out;
    dz = div_by_zero;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    total++; if (out !== 32'h0)     begin bad++; $display("FAIL reset_out got=%h want=0", out); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [6] = '{32'h40C00000, 32'h3F800000, 32'hC0000000, 32'h00000000, 32'h7F000000, 32'h00800000};
    logic [31:0] tb [6] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h00800000, 32'h7F000000};
`ifdef FP_DIV_ROUND_EN
    logic [31:0] tq [6] = '{32'h40400000, 32'h3EAAAAAB, 32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
`else
    logic [31:0] tq [6] = '{32'h40400000, 32'h3EAAAAAA, 32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
`endif
    logic        td [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int          tl [6] = '{28, 28, 2, 2, 28, 28};
    logic [31:0] r;
    logic        dz;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], r, dz, lat);
      total++; if (r !== tq[i])  begin bad++; $display("FAIL dir%0d_out got=%h want=%h", i, r, tq[i]); end
      total++; if (dz !== td[i]) begin bad++; $display("FAIL dir%0d_dbz got=%b want=%b", i, dz, td[i]); end
      total++; if (lat != tl[i]) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, tl[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, er;
    logic        dz, edz, sp;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      a = rnd_fp();
      b = rnd_fp();
      model(a, b, er, edz, sp);
      run_op(a, b, r, dz, lat);
      total++; if (r !== er)   begin bad++; $display("FAIL rnd_out a=%h b=%h got=%h want=%h", a, b, r, er); end
      total++; if (dz !== edz) begin bad++; $display("FAIL rnd_dbz a=%h b=%h got=%b want=%b", a, b, dz, edz); end
      total++; if (lat != (sp ? 2 : 28)) begin bad++; $display("FAIL rnd_latency a=%h b=%h got=%0d want=%0d", a, b, lat, sp ? 2 : 28); end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    out_ready = 1'b0;
    in0 = 32'h40C00000; in1 = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in0 = 32'h3F800000; in1 = 32'h40400000;  // must be ignored while busy
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    total++; if (n != 28) begin bad++; $display("FAIL bp_latency got=%0d want=28", n); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out !== 32'h40400000 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%b out=%h rdy=%b want v=1 out=40400000 rdy=0", i, out_valid, out, in_ready);
      end
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r;
    logic        dz;
    int          lat;
    in0 = 32'h40C00000; in1 = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b want=1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out !== 32'h0) begin
      bad++; $display("FAIL abort_state got v=%b busy=%b rdy=%b out=%h want v=0 busy=0 rdy=1 out=0", out_valid, busy, in_ready, out);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h40C00000, 32'h40000000, r, dz, lat);
    total++; if (r !== 32'h40400000) begin bad++; $display("FAIL abort_redo_out got=%h want=40400000", r); end
    total++; if (lat != 28) begin bad++; $display("FAIL abort_redo_latency got=%0d want=28", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
